// File: rtl/display_pkg.sv
// Shared display types for the seven-segment feeder path, plus the
// leading-zero blank rule used wherever a 16-bit word is shown on four digits.
package display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int NUM_DIGITS = 4;
    localparam int WORD_W     = NIBBLE_W * NUM_DIGITS;

    typedef logic [WORD_W-1:0]     disp_word_t;
    typedef logic [NUM_DIGITS-1:0] blank_t;

    // Digit 0 is never blanked so an all-zero word still shows a single "0".
    function automatic blank_t leading_blank(input disp_word_t w);
        blank_t b;
        b    = '0;
        b[3] = (w[15:12] == 4'h0);
        b[2] = b[3] & (w[11:8] == 4'h0);
        b[1] = b[2] & (w[7:4] == 4'h0);
        return b;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, hold-time debouncer and a
// one-cycle press pulse on each accepted released->pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Key_n,
    output logic Press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= Key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign Press = press_q;

endmodule

// File: rtl/hex_page_sequencer.sv
// Steps through NUM_PAGES debug words on a debounced key and registers the
// selected word as four nibbles with leading-zero blank flags.
module hex_page_sequencer
    import display_pkg::*;
#(
    parameter int NUM_PAGES       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLANK_EN        = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Key_n,
    input  logic                         Freeze,
    input  logic [WORD_W*NUM_PAGES-1:0]  Page_in,
    output logic [$clog2(NUM_PAGES)-1:0] Page_sel,
    output logic [WORD_W-1:0]            Hex_out,
    output logic [NUM_DIGITS-1:0]        Blank,
    output logic                         Upd
);

    localparam int     SEL_W     = $clog2(NUM_PAGES);
    localparam blank_t BLANK_RST = (BLANK_EN != 0) ? blank_t'(4'b1110) : blank_t'(4'b0000);

    logic             press;
    logic [SEL_W-1:0] page_q, page_d;
    logic [SEL_W-1:0] shown_q, shown_d;
    disp_word_t       hex_q, hex_d;
    blank_t           blank_q, blank_d;
    logic             upd_q, upd_d;
    disp_word_t       word;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .Clk  (Clk),
        .Reset(Reset),
        .Key_n(Key_n),
        .Press(press)
    );

    // shown_q remembers which page the capture register holds, so Upd fires
    // on page changes only and never on live data changes within a page.
    always_comb begin
        page_d = page_q;
        if (press) begin
            page_d = (page_q == SEL_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
        end

        word = '0;
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (page_q == SEL_W'(k)) begin
                word = Page_in[k*WORD_W +: WORD_W];
            end
        end

        hex_d   = hex_q;
        blank_d = blank_q;
        shown_d = shown_q;
        upd_d   = 1'b0;
        if (!Freeze) begin
            hex_d   = word;
            blank_d = (BLANK_EN != 0) ? leading_blank(word) : '0;
            shown_d = page_q;
            upd_d   = (page_q != shown_q);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            page_q  <= '0;
            shown_q <= '0;
            hex_q   <= '0;
            blank_q <= BLANK_RST;
            upd_q   <= 1'b0;
        end else begin
            page_q  <= page_d;
            shown_q <= shown_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            upd_q   <= upd_d;
        end
    end

    assign Page_sel = page_q;
    assign Hex_out  = hex_q;
    assign Blank    = blank_q;
    assign Upd      = upd_q;

endmodule
